eth_pcs_rx_block_lock: RTL and testbench

Receive-side sync-header lock controller for the 10GBASE-R PCS, per IEEE 802.3 Clause 49 block_lock and BER monitor behaviour. It samples the 2-bit sync header that the RX gearbox presents and decides when 66-bit block alignment is acquired or lost. It drives a one-cycle slip request back to the gearbox to shift alignment, and reports block_lock, hi_ber and a combined rx_status to the descrambler/decoder path and management.

---
 rtl/eth_pcs_rx_block_lock_if.sv | 23 ++
 rtl/eth_pcs_rx_block_lock.sv | 129 ++++++++++++
 tb/tb_eth_pcs_rx_block_lock.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_pcs_rx_block_lock_if.sv
// eth_pcs_rx_block_lock_if: sync-header feed from the RX gearbox plus slip request and lock/BER status.
interface eth_pcs_rx_block_lock_if #(
    parameter int W_SYNC = 2
);
    logic              i_clk_en;
    logic              i_hdr_valid;
    logic [W_SYNC-1:0] i_hdr;
    logic              o_slip;
    logic              o_block_lock;
    logic              o_hi_ber;
    logic              o_rx_status;
    logic [5:0]        o_ber_cnt;

    modport master (
        output i_clk_en, i_hdr_valid, i_hdr,
        input  o_slip, o_block_lock, o_hi_ber, o_rx_status, o_ber_cnt
    );

    modport slave (
        input  i_clk_en, i_hdr_valid, i_hdr,
        output o_slip, o_block_lock, o_hi_ber, o_rx_status, o_ber_cnt
    );
endinterface

// File: rtl/eth_pcs_rx_block_lock.sv
// eth_pcs_rx_block_lock: 10GBASE-R sync-header block lock FSM with gearbox slip control and BER monitor.
module eth_pcs_rx_block_lock #(
    parameter int N_SH_CHECK = 64,
    parameter int N_SH_INVLD = 16,
    parameter int SLIP_WAIT  = 4,
    parameter int BER_WINDOW = 19531,
    parameter int BER_THRESH = 16
) (
    input logic                    i_clk,
    input logic                    i_reset,
    eth_pcs_rx_block_lock_if.slave gb
);
    localparam int SH_W   = $clog2(N_SH_CHECK + 1);
    localparam int INV_W  = $clog2(N_SH_INVLD + 1);
    localparam int SLIP_W = SLIP_WAIT > 0 ? $clog2(SLIP_WAIT + 1) : 1;
    localparam int WIN_W  = $clog2(BER_WINDOW + 1);
    localparam int BC_W   = $clog2(BER_THRESH + 1);

    localparam logic [1:0] LOCK_INIT = 2'd0;
    localparam logic [1:0] TEST_SH   = 2'd1;
    localparam logic [1:0] SLIP      = 2'd2;
    localparam logic [1:0] WAIT_SLIP = 2'd3;

    logic [1:0]        state, state_d;
    logic [SH_W-1:0]   sh_cnt, sh_cnt_d, sh_inc;
    logic [INV_W-1:0]  invld_cnt, invld_d, inv_inc;
    logic [SLIP_W-1:0] slip_cnt, slip_cnt_d;
    logic              lock, lock_d, slip, slip_d;
    logic [WIN_W-1:0]  win_cnt, win_d, win_inc;
    logic [BC_W-1:0]   ber_cnt, ber_cnt_d, bc_inc;
    logic [5:0]        ber_out, ber_out_d, bo_inc;
    logic              hi_ber, hi_ber_d, rx_status;
    logic              ev, bad, ber_on, win_end, thr;

    assign ev      = gb.i_clk_en & gb.i_hdr_valid;
    assign bad     = ~^gb.i_hdr;
    assign sh_inc  = sh_cnt + SH_W'(1);
    assign inv_inc = invld_cnt + INV_W'(bad);

    always_comb begin
        state_d    = state;
        sh_cnt_d   = sh_cnt;
        invld_d    = invld_cnt;
        slip_cnt_d = slip_cnt;
        lock_d     = lock;
        slip_d     = 1'b0;
        case (state)
            LOCK_INIT: begin
                lock_d   = 1'b0;
                sh_cnt_d = '0;
                invld_d  = '0;
                state_d  = TEST_SH;
            end
            TEST_SH: if (ev) begin
                // a slip outranks a coincident window end
                if (bad && (!lock || inv_inc == INV_W'(N_SH_INVLD))) begin
                    lock_d  = 1'b0;
                    slip_d  = 1'b1;
                    state_d = SLIP;
                end else if (sh_inc == SH_W'(N_SH_CHECK)) begin
                    lock_d   = lock | (inv_inc == '0);
                    sh_cnt_d = '0;
                    invld_d  = '0;
                end else begin
                    sh_cnt_d = sh_inc;
                    invld_d  = inv_inc;
                end
            end
            SLIP: begin
                sh_cnt_d   = '0;
                invld_d    = '0;
                slip_cnt_d = SLIP_W'(SLIP_WAIT);
                state_d    = WAIT_SLIP;
            end
            default: if (slip_cnt == '0) begin
                state_d = TEST_SH;
            end else if (ev) begin
                slip_cnt_d = slip_cnt - SLIP_W'(1);
                state_d    = slip_cnt == SLIP_W'(1) ? TEST_SH : WAIT_SLIP;
            end
        endcase
    end

    // the monitor only sees events with lock held on both sides of the edge
    assign ber_on    = lock & lock_d;
    assign win_inc   = win_cnt + WIN_W'(1);
    assign bc_inc    = ber_cnt + BC_W'(bad && ber_cnt != BC_W'(BER_THRESH));
    assign bo_inc    = ber_out + 6'(bad && ber_out != 6'd63);
    assign win_end   = win_inc == WIN_W'(BER_WINDOW);
    assign thr       = bc_inc == BC_W'(BER_THRESH);
    assign win_d     = !ber_on ? '0 : !ev ? win_cnt : win_end ? '0 : win_inc;
    assign ber_cnt_d = !ber_on ? '0 : !ev ? ber_cnt : win_end ? '0 : bc_inc;
    assign ber_out_d = !ber_on ? '0 : !ev ? ber_out : win_end ? '0 : bo_inc;
    assign hi_ber_d  = !ber_on ? 1'b0 : !ev ? hi_ber : win_end ? thr : hi_ber | thr;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= LOCK_INIT;
            sh_cnt    <= '0;
            invld_cnt <= '0;
            slip_cnt  <= '0;
            lock      <= 1'b0;
            slip      <= 1'b0;
            win_cnt   <= '0;
            ber_cnt   <= '0;
            ber_out   <= '0;
            hi_ber    <= 1'b0;
            rx_status <= 1'b0;
        end else begin
            state     <= state_d;
            sh_cnt    <= sh_cnt_d;
            invld_cnt <= invld_d;
            slip_cnt  <= slip_cnt_d;
            lock      <= lock_d;
            slip      <= slip_d;
            win_cnt   <= win_d;
            ber_cnt   <= ber_cnt_d;
            ber_out   <= ber_out_d;
            hi_ber    <= hi_ber_d;
            rx_status <= lock_d & ~hi_ber_d;
        end
    end

    assign gb.o_slip       = slip;
    assign gb.o_block_lock = lock;
    assign gb.o_hi_ber     = hi_ber;
    assign gb.o_rx_status  = rx_status;
    assign gb.o_ber_cnt    = ber_out;
endmodule

// File: tb/tb_eth_pcs_rx_block_lock.sv
// tb_eth_pcs_rx_block_lock: randomized stimulus, reference model feeding a per-cycle scoreboard.
module tb_eth_pcs_rx_block_lock;
    localparam int N_SH_CHECK = 64;
    localparam int N_SH_INVLD = 16;
    localparam int SLIP_WAIT  = 4;
    localparam int BER_WINDOW = 128;
    localparam int BER_THRESH = 16;

    typedef struct packed {
        logic       slip;
        logic       lock;
        logic       hi;
        logic       rx;
        logic [5:0] bc;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_reset = 1'b0;
    always #5 i_clk = ~i_clk;

    eth_pcs_rx_block_lock_if gb();

    eth_pcs_rx_block_lock #(
        .N_SH_CHECK(N_SH_CHECK),
        .N_SH_INVLD(N_SH_INVLD),
        .SLIP_WAIT(SLIP_WAIT),
        .BER_WINDOW(BER_WINDOW),
        .BER_THRESH(BER_THRESH)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .gb(gb)
    );

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   rates[4] = '{0, 1, 3, 8};

    bit m_lock, m_hi, m_hold;
    int m_skip_ev, m_sh_n, m_sh_bad, m_ber_n, m_ber_bad;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behaviour after one clock edge: windows counted as event tallies, slips as ignored cycles/events.
    task automatic model(input bit rst_n, input bit ev, input bit bad, output exp_t e);
        bit was_lock;
        bit slip;
        was_lock = m_lock;
        slip = 1'b0;
        if (!rst_n) begin
            m_lock = 0; m_hi = 0; m_hold = 1; m_skip_ev = 0;
            m_sh_n = 0; m_sh_bad = 0; m_ber_n = 0; m_ber_bad = 0;
        end else if (m_hold) begin
            m_hold = 0;
        end else if (m_skip_ev > 0) begin
            if (ev) m_skip_ev--;
        end else if (ev) begin
            m_sh_n++;
            m_sh_bad += int'(bad);
            if (bad && (!m_lock || m_sh_bad == N_SH_INVLD)) begin
                m_lock = 0; slip = 1; m_hold = 1; m_skip_ev = SLIP_WAIT;
                m_sh_n = 0; m_sh_bad = 0;
            end else if (m_sh_n == N_SH_CHECK) begin
                if (m_sh_bad == 0) m_lock = 1;
                m_sh_n = 0; m_sh_bad = 0;
            end
        end
        if (!(was_lock && m_lock)) begin
            m_ber_n = 0; m_ber_bad = 0; m_hi = 0;
        end else if (ev) begin
            m_ber_n++;
            m_ber_bad += int'(bad);
            if (m_ber_bad >= BER_THRESH) m_hi = 1;
            if (m_ber_n == BER_WINDOW) begin
                m_hi = m_ber_bad >= BER_THRESH;
                m_ber_n = 0; m_ber_bad = 0;
            end
        end
        e.slip = slip;
        e.lock = m_lock;
        e.hi   = m_hi;
        e.rx   = m_lock & ~m_hi;
        e.bc   = 6'(m_ber_bad > 63 ? 63 : m_ber_bad);
    endtask

    task automatic step(input bit rst_n, input bit ce, input bit hv, input logic [1:0] h);
        exp_t e;
        i_reset = rst_n;
        gb.i_clk_en = ce;
        gb.i_hdr_valid = hv;
        gb.i_hdr = h;
        model(rst_n, ce & hv, ~^h, e);
        sb.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [1:0] pick(input bit b);
        logic [1:0] v;
        v = b ? 2'b00 : 2'b01;
        return $urandom_range(1) != 0 ? ~v : v;
    endfunction

    task automatic gap();
        bit c;
        c = 1'($urandom_range(1));
        step(1, c, ~c, 2'($urandom));
    endtask

    task automatic send(input bit bad);
        while ($urandom_range(3) == 0) gap();
        step(1, 1, 1, pick(bad));
    endtask

    task automatic window(input int n, input int k);
        int left;
        bit b;
        left = k;
        for (int i = 0; i < n; i++) begin
            b = $urandom_range(n - i - 1) < left;
            if (b) left--;
            send(b);
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 2'($urandom));
        step(1, 0, 0, 2'b00);
    endtask

    initial begin
        @(posedge i_clk);
        forever begin
            @(negedge i_clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("slip", 8'(gb.o_slip), 8'(e.slip));
                chk("block_lock", 8'(gb.o_block_lock), 8'(e.lock));
                chk("hi_ber", 8'(gb.o_hi_ber), 8'(e.hi));
                chk("rx_status", 8'(gb.o_rx_status), 8'(e.rx));
                chk("ber_cnt", 8'(gb.o_ber_cnt), 8'(e.bc));
            end
        end
    end

    initial begin
        do_reset(2);
        window(64, 0);
        repeat (20) gap();
        window(64, 15);
        window(64, 16);
        repeat (5) gap();
        do_reset(1);
        window(10, 0);
        send(1);
        step(1, 0, 1, 2'b11);
        window(4, 4);
        window(64, 0);
        do_reset(1);
        window(64, 0);
        window(64, 8);
        window(64, 8);
        window(64, 2);
        window(64, 1);
        window(64, 8);
        window(64, 8);
        do_reset(1);
        window(64, 0);
        do_reset(1);
        window(5, 0);
        send(1);
        step(1, 0, 1, 2'b00);
        window(2, 2);
        do_reset(1);
        window(64, 0);
        do_reset(1);
        window(3, 0);
        send(1);
        do_reset(1);
        window(64, 0);
        for (int s = 0; s < 8; s++) begin
            repeat (500) begin
                if ($urandom_range(299) == 0) do_reset(1);
                else step(1, $urandom_range(7) != 0, $urandom_range(7) != 0,
                          $urandom_range(99) < rates[s % 4] ? pick(1) : pick(0));
            end
        end
        @(negedge i_clk);
        #1;
        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
